// File: rtl/pp_hazard_pkg.sv
// Shared definitions for the decode-stage hazard logic.
// Holds the forwarding-select encodings, the in-flight pipeline entry
// record and a helper that tells whether an entry will really write a
// register.
// HZ_RN_W is the register-number width that pipe_entry_t is built with.
// Every module that imports this package must use the same RN_W.
package pp_hazard_pkg;

  localparam int HZ_RN_W = 5;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  typedef struct packed {
    logic               v;
    logic               wreg;
    logic               m2reg;
    logic [HZ_RN_W-1:0] rn;
  } pipe_entry_t;

  // Register 0 is hardwired to zero, so a write to it never creates a
  // dependency.
  function automatic logic entry_live(input pipe_entry_t e);
    return e.v & e.wreg & (e.rn != '0);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_fwd_sel.sv
// Forwarding-select generator for one decode source operand.
// Ports:
//   src     - source register number read by the decoded instruction
//   use_src - the instruction really reads src
//   ex_e    - entry currently in EX
//   mem_e   - entry currently in MEM
//   sel     - operand source: register file, EX ALU, MEM ALU or MEM load
module fwd_sel
  import pp_hazard_pkg::*;
#(
  parameter int RN_W = HZ_RN_W
) (
  input  logic [RN_W-1:0] src,
  input  logic            use_src,
  input  pipe_entry_t     ex_e,
  input  pipe_entry_t     mem_e,
  output logic [1:0]      sel
);

  // The youngest producer wins. A matching load in EX shadows an older
  // MEM producer of the same register; its data does not exist yet, so the
  // select stays at the register file while the stall logic holds decode.
  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != '0)) begin
      if (entry_live(ex_e) && (ex_e.rn == src)) begin
        if (!ex_e.m2reg) begin
          sel = FWD_EXALU;
        end
      end else if (entry_live(mem_e) && (mem_e.rn == src)) begin
        sel = mem_e.m2reg ? FWD_MEMLD : FWD_MEMALU;
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard for a 5-stage pipeline.
// Tracks the destination register of the instructions in EX, MEM and WB,
// produces forwarding selects for rs/rt, detects load-use hazards (stall
// plus bubble insertion) and drives the register-file write port from WB.
// Ports:
//   clk, clrn            - clock, asynchronous active-low reset
//   id_*                 - decoded instruction fields
//   hold                 - external freeze, every stage keeps its contents
//   fwda, fwdb           - forwarding selects for operands a and b
//   stall, wpcir         - load-use stall and PC / IF-ID write enable
//   ex_*, mem_*          - controls of the EX and MEM entries
//   wb_wreg, wb_rn       - register-file write enable and address
// Optional macro HZ_STATS_EN adds saturating counters stall_cnt and fwd_cnt
// (width CNT_W) for stall cycles and forwarded decode cycles.
module id_hazard_scoreboard
  import pp_hazard_pkg::*;
#(
  parameter int RN_W = HZ_RN_W
`ifdef HZ_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            id_valid,
  input  logic [RN_W-1:0] id_rs,
  input  logic [RN_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RN_W-1:0] id_rn,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            hold,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            stall,
  output logic            wpcir,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic [RN_W-1:0] ex_rn,
  output logic            mem_wreg,
  output logic            mem_m2reg,
  output logic [RN_W-1:0] mem_rn,
  output logic            wb_wreg,
  output logic [RN_W-1:0] wb_rn
`ifdef HZ_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  pipe_entry_t ex_q, ex_d;
  pipe_entry_t mem_q, mem_d;
  pipe_entry_t wb_q, wb_d;

  fwd_sel #(.RN_W(RN_W)) u_fwd_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .ex_e    (ex_q),
    .mem_e   (mem_q),
    .sel     (fwda)
  );

  fwd_sel #(.RN_W(RN_W)) u_fwd_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .ex_e    (ex_q),
    .mem_e   (mem_q),
    .sel     (fwdb)
  );

  // A load in EX has no data until it reaches MEM, so a dependent reader
  // must wait exactly one cycle. Only the EX entry can cause a stall.
  always_comb begin
    stall = id_valid & entry_live(ex_q) & ex_q.m2reg &
            ((id_use_rs & (ex_q.rn == id_rs)) |
             (id_use_rt & (ex_q.rn == id_rt)));
    wpcir = ~stall & ~hold;
  end

  // Hold freezes everything, including the bubble a stall would insert.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (id_valid && !stall) begin
        ex_d.v     = 1'b1;
        ex_d.wreg  = id_wreg;
        ex_d.m2reg = id_m2reg;
        ex_d.rn    = id_rn;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Bubbles are all-zero, so the raw fields can be exported directly.
  assign ex_wreg   = ex_q.wreg;
  assign ex_m2reg  = ex_q.m2reg;
  assign ex_rn     = ex_q.rn;
  assign mem_wreg  = mem_q.wreg;
  assign mem_m2reg = mem_q.m2reg;
  assign mem_rn    = mem_q.rn;
  assign wb_wreg   = wb_q.wreg;
  assign wb_rn     = wb_q.rn;

`ifdef HZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Both counters saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !hold && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!hold && id_valid && ((fwda != FWD_RF) || (fwdb != FWD_RF)) && !(&fwd_cnt_q)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Testbench for id_hazard_scoreboard: directed hazard sequences followed by
// random instruction streams, all compared against a stage-array model.
module tb_id_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, hold;
  logic [4:0] id_rs, id_rt, id_rn;
  logic [1:0] fwda, fwdb;
  logic       stall, wpcir;
  logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
  logic [4:0] ex_rn, mem_rn, wb_rn;
`ifdef HZ_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int checkCount = 0;
  int passCount = 0;

  // Model: index 0 = EX, 1 = MEM, 2 = WB
  logic       mv[3];
  logic       mw[3];
  logic       mm[3];
  logic [4:0] mr[3];
  int         expStallCnt;
  int         expFwdCnt;

  id_hazard_scoreboard dut (
    .clk       (clk),
    .clrn      (clrn),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_rn     (id_rn),
    .id_wreg   (id_wreg),
    .id_m2reg  (id_m2reg),
    .hold      (hold),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .stall     (stall),
    .wpcir     (wpcir),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .wb_wreg   (wb_wreg),
    .wb_rn     (wb_rn)
`ifdef HZ_STATS_EN
    , .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic live(input int i);
    return mv[i] && mw[i] && (mr[i] != 5'd0);
  endfunction

  // Search from youngest to oldest for the first in-flight writer of src.
  function automatic logic [1:0] refFwd(input logic [4:0] src, input logic u);
    if (!u || src == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (live(i) && mr[i] == src) begin
        if (i == 0) return mm[0] ? 2'b00 : 2'b01;
        return mm[1] ? 2'b11 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  // A load in EX matching a read source: the select is moot, decode stalls.
  function automatic logic shadowed(input logic [4:0] src, input logic u);
    return u && live(0) && mm[0] && mr[0] == src;
  endfunction

  function automatic logic refStall();
    return id_valid && live(0) && mm[0] &&
           ((id_use_rs && mr[0] == id_rs) || (id_use_rt && mr[0] == id_rt));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0; mw[i] = 1'b0; mm[i] = 1'b0; mr[i] = 5'd0;
    end
    expStallCnt = 0;
    expFwdCnt = 0;
  endtask

  task automatic checkAll();
    logic st;
    st = refStall();
    if (!shadowed(id_rs, id_use_rs)) checkOutput("fwda", fwda, refFwd(id_rs, id_use_rs));
    if (!shadowed(id_rt, id_use_rt)) checkOutput("fwdb", fwdb, refFwd(id_rt, id_use_rt));
    checkOutput("stall", stall, st);
    checkOutput("wpcir", wpcir, !st && !hold);
    checkOutput("ex_wreg", ex_wreg, mw[0]);
    checkOutput("ex_m2reg", ex_m2reg, mm[0]);
    checkOutput("ex_rn", ex_rn, mr[0]);
    checkOutput("mem_wreg", mem_wreg, mw[1]);
    checkOutput("mem_m2reg", mem_m2reg, mm[1]);
    checkOutput("mem_rn", mem_rn, mr[1]);
    checkOutput("wb_wreg", wb_wreg, mw[2]);
    checkOutput("wb_rn", wb_rn, mr[2]);
`ifdef HZ_STATS_EN
    checkOutput("stall_cnt", stall_cnt, expStallCnt);
    checkOutput("fwd_cnt", fwd_cnt, expFwdCnt);
`endif
  endtask

  task automatic setInputs(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic [4:0] rn,
                           input logic wr, input logic ld, input logic hd);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rn = rn; id_wreg = wr; id_m2reg = ld; hold = hd;
  endtask

  // Advance one clock and move the model by the same rules.
  task automatic stepClock();
    logic st;
    logic [1:0] fa, fb;
    st = refStall();
    fa = refFwd(id_rs, id_use_rs);
    fb = refFwd(id_rt, id_use_rt);
    @(posedge clk);
    if (!hold) begin
      if (st) expStallCnt++;
      if (id_valid && (fa != 2'b00 || fb != 2'b00)) expFwdCnt++;
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1]; mw[i] = mw[i-1]; mm[i] = mm[i-1]; mr[i] = mr[i-1];
      end
      if (id_valid && !st) begin
        mv[0] = 1'b1; mw[0] = id_wreg; mm[0] = id_m2reg; mr[0] = id_rn;
      end else begin
        mv[0] = 1'b0; mw[0] = 1'b0; mm[0] = 1'b0; mr[0] = 5'd0;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] rn,
                               input logic wr, input logic ld, input logic hd);
    setInputs(v, rs, rt, urs, urt, rn, wr, ld, hd);
    #2;
    checkAll();
    stepClock();
  endtask

  initial begin
    modelReset();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkAll();
    checkOutput("reset_wpcir", wpcir, 1);
    #9 clrn = 1'b1;
    @(posedge clk);
    #1;

    // ALU hazard: add r3 ; sub r5,r3,r4 ; or r6,r3
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0);
    setInputs(1, 3, 4, 1, 1, 5, 1, 0, 0);
    #2; checkAll(); checkOutput("alu_ex_fwda", fwda, 2'b01); stepClock();
    setInputs(1, 3, 0, 1, 0, 6, 1, 0, 0);
    #2; checkAll(); checkOutput("alu_mem_fwda", fwda, 2'b10); stepClock();

    // Load-use: lw r2 ; add r6,r2,r2
    applyStimulus(1, 0, 0, 1, 0, 2, 1, 1, 0);
    setInputs(1, 2, 2, 1, 1, 6, 1, 0, 0);
    #2; checkAll(); checkOutput("lu_stall", stall, 1); checkOutput("lu_wpcir", wpcir, 0); stepClock();
    #2; checkAll();
    checkOutput("lu_bubble", ex_wreg, 0); checkOutput("lu_fwda", fwda, 2'b11);
    checkOutput("lu_fwdb", fwdb, 2'b11); checkOutput("lu_nostall", stall, 0);
    stepClock();

    // Register 0 load never stalls or forwards
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0);
    setInputs(1, 0, 0, 1, 1, 8, 1, 0, 0);
    #2; checkAll(); checkOutput("r0_stall", stall, 0); checkOutput("r0_fwda", fwda, 2'b00); stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; checkOutput("r0_wb_wreg", wb_wreg, 1); checkOutput("r0_wb_rn", wb_rn, 0);

    // Priority: two writers of r7, youngest wins
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0);
    setInputs(1, 7, 0, 1, 0, 9, 1, 0, 0);
    #2; checkAll(); checkOutput("prio_fwda", fwda, 2'b01); stepClock();

    // Hold during load-use
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      setInputs(1, 2, 0, 1, 0, 6, 1, 0, 1);
      #2; checkAll(); checkOutput("hold_stall", stall, 1); checkOutput("hold_wpcir", wpcir, 0);
      checkOutput("hold_ex_m2reg", ex_m2reg, 1);
      stepClock();
    end
    applyStimulus(1, 2, 0, 1, 0, 6, 1, 0, 0);
    setInputs(1, 2, 0, 1, 0, 6, 1, 0, 0);
    #2; checkAll(); checkOutput("hold_rel_stall", stall, 0); checkOutput("hold_rel_fwda", fwda, 2'b11);
    stepClock();

    // Reset while stalling
    applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 0);
    setInputs(1, 4, 0, 1, 0, 6, 1, 0, 0);
    #2; checkOutput("pre_rst_stall", stall, 1);
    clrn = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_wpcir", wpcir, 1);
    checkOutput("rst_ex_m2reg", ex_m2reg, 0);
    checkAll();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 clrn = 1'b1;
    stepClock();

    // Random streams over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0));
    end
    #2; checkAll();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Sequencing controller for the decode stage of the 5-stage pipelined CPU.
- Tracks destination-register info for instructions in flight in EX, MEM and WB.
- Generates operand-forwarding selects for decode sources rs/rt and a load-use stall (PC/IF-ID write-enable) with bubble insertion.
- Drives the register-file write-port controls (wb_wreg, wb_rn) from its WB entry.

Parameters:
- RN_W, 5: register-number width; register 0 is hardwired zero.
- CNT_W, 32: width of stall statistics counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- clrn  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a real instruction (0 = bubble)
- id_rs  in  RN_W  source register a
- id_rt  in  RN_W  source register b
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt (0 for immediate-only forms)
- id_rn  in  RN_W  destination register (rd/rt after regrt mux)
- id_wreg  in  1  instruction writes register file
- id_m2reg  in  1  instruction is a load
- hold  in  1  external freeze (memory not ready); all stages hold
- fwda  out  2  forward select for operand a
- fwdb  out  2  forward select for operand b
- stall  out  1  load-use stall: PC and IF/ID must not update
- wpcir  out  1  = ~stall & ~hold
- ex_wreg, ex_m2reg  out  1 each  EX entry controls
- ex_rn  out  RN_W  EX destination
- mem_wreg, mem_m2reg  out  1 each  MEM entry controls
- mem_rn  out  RN_W  MEM destination
- wb_wreg  out  1  register-file write enable
- wb_rn  out  RN_W  register-file write address

Behaviour:
- State: three entries {v, wreg, m2reg, rn} for EX, MEM and WB.
- Reset (clrn=0, async): all entries cleared.
  - All *_wreg, *_m2reg, *_rn = 0.
  - fwda = fwdb = 0, stall = 0, wpcir = 1.
  - Applies at any time, including mid-stall.
- Entry "live" = v & wreg & (rn != 0).
- Forwarding select, same rule for fwdb with id_rt/id_use_rt; combinational, same cycle, highest priority first:
  - 2'b00 (default, register file): no match, or id_use_rs=0, or id_rs=0.
  - 2'b01: EX live, ex_rn==id_rs, ex_m2reg=0 (EX ALU result).
  - 2'b10: MEM live, mem_rn==id_rs, mem_m2reg=0 (MEM ALU result).
  - 2'b11: MEM live, mem_rn==id_rs, mem_m2reg=1 (MEM load data).
  - EX match takes priority over MEM match (youngest wins).
  - WB match needs no forwarding: the register file writes on clk falling edge.
- stall = id_valid & EX live & ex_m2reg & ((id_use_rs & ex_rn==id_rs) | (id_use_rt & ex_rn==id_rt)).
  - Combinational.
- Posedge clk, hold=0:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (all 0) if stall or id_valid=0.
  - Otherwise EX <= {1, id_wreg, id_m2reg, id_rn}.
- Posedge clk, hold=1:
  - All entries hold.
  - stall still evaluated, but no bubble is inserted.
  - wpcir = 0.
- Load-use latency: exactly one bubble.
  - The cycle after a stall, the load sits in MEM and the consumer gets fwd = 2'b11.
- Load with destination 0, or wreg=0: never stalls, never forwards.
- Back-to-back loads to the same register: the younger (EX) one is the stall target; the older MEM one is ignored.
- id_valid=0: stall=0, fwda/fwdb still computed but ignored by the datapath.

Optional Feature:
- Macro HZ_STATS_EN.
- When defined:
  - Adds outputs stall_cnt and fwd_cnt, CNT_W each.
  - stall_cnt increments on each posedge with stall=1 & hold=0.
  - fwd_cnt increments on each posedge with hold=0 & id_valid=1 & (fwda!=0 | fwdb!=0).
  - Both saturate at all-ones and clear on reset.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pp_hazard_pkg:
  - FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11.
  - Typedef pipe_entry_t {v, wreg, m2reg, rn[RN_W-1:0]}.
- One sub-module, fwd_sel: one source register plus EX/MEM entries in, 2-bit select out. Instantiated twice (rs, rt).

Test Plan:
- ALU hazard: add r3 decoded, then sub r5,r3,r4 next cycle -> fwda=2'b01, stall=0; next cycle (r3 in MEM) with a reader of r3 -> fwda=2'b10.
- Load-use: lw r2 then add r6,r2,r2 -> stall=1 and wpcir=0 for one cycle, EX bubble (ex_wreg=0); next cycle fwda=fwdb=2'b11, stall=0.
- Register 0: lw r0 then consumer of r0 -> stall=0, fwda=2'b00; wb_wreg=1 with wb_rn=0 passes harmlessly.
- Priority: ALU writes r7 (now MEM), then ALU writes r7 (now EX), decode reads r7 -> fwda=2'b01.
- hold during load-use: hold=1 for 3 cycles -> entries unchanged, wpcir=0, no bubble; on release, stall for exactly one cycle.
- Reset mid-stall: assert clrn=0 while stall=1 -> all outputs 0 and wpcir=1 immediately; with HZ_STATS_EN, stall_cnt=0.
